// File: rtl/pc_flow_controller_pkg.sv
// ---------------------------------------------------------------------------
// pc_flow_controller_pkg : shared select codes and FSM encoding.   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_flow_controller_pkg;

   localparam logic [1:0] SEL_ADDER = 2'b00;
   localparam logic [1:0] SEL_STACK = 2'b01;
   localparam logic [1:0] SEL_JUMP  = 2'b10;

   localparam logic OPB_DISP = 1'b0;
   localparam logic OPB_ONE  = 1'b1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_flow_controller_return_stack.sv
// ---------------------------------------------------------------------------
// return_stack : parameterised LIFO holding call return addresses.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module return_stack #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 12,
   parameter int PTR_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [WIDTH-1:0]     push_data,
   output logic [WIDTH-1:0]     top,
   output logic                 empty,
   output logic                 full
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_MAX = PTR_WIDTH'(DEPTH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [PTR_WIDTH-1:0] sp;
   logic [IDX_W-1:0]     top_idx;
   logic [IDX_W-1:0]     wr_idx;

   assign empty   = (sp == '0);
   assign full    = (sp == PTR_MAX);
   assign top_idx = IDX_W'(sp - PTR_ONE);
   assign wr_idx  = IDX_W'(sp);
   assign top     = empty ? '0 : mem[top_idx];

   // Pop only moves the pointer; stale entries stay until overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !full) begin
         mem[wr_idx] <= push_data;
         sp          <= sp + PTR_ONE;
      end else if (pop && !empty) begin
         sp <= sp - PTR_ONE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_flow_controller.sv
// ---------------------------------------------------------------------------
// pc_flow_controller : fetch redirect priority decode, flush/fault FSM.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_flow_controller
   import pc_flow_controller_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int STACK_DEPTH = 8,
   parameter int PTR_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  isJmp,
   input  logic                  isJsb,
   input  logic                  isRet,
   input  logic                  brTaken,
   input  logic [ADDR_WIDTH-1:0] pushAdr,
   output logic [1:0]            pcInputSel,
   output logic                  pcAdderInputBSel,
   output logic                  pcWrite,
   output logic                  flush,
   output logic [ADDR_WIDTH-1:0] stackOutput,
   output logic                  stackEmpty,
   output logic                  stackFull,
   output logic                  fault
);

   state_t                state;
   state_t                state_nxt;
   logic                  run;
   logic                  eff_stall, eff_jmp, eff_jsb, eff_ret, eff_br;
   logic                  push_en, pop_en;
   logic [ADDR_WIDTH-1:0] stack_top;
   logic                  stack_empty, stack_full;

   return_stack #(
      .DEPTH     (STACK_DEPTH),
      .WIDTH     (ADDR_WIDTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push_en),
      .pop       (pop_en),
      .push_data (pushAdr),
      .top       (stack_top),
      .empty     (stack_empty),
      .full      (stack_full)
   );

   assign run       = (state == ST_RUN);
   assign eff_stall = stall   & run;
   assign eff_jmp   = isJmp   & run;
   assign eff_jsb   = isJsb   & run;
   assign eff_ret   = isRet   & run;
   assign eff_br    = brTaken & run;

   always_comb begin
      pcInputSel       = SEL_ADDER;
      pcAdderInputBSel = OPB_ONE;
      pcWrite          = 1'b1;
      flush            = 1'b0;
      push_en          = 1'b0;
      pop_en           = 1'b0;
      state_nxt        = state;

      case (state)
         ST_RUN: begin
            if (eff_stall) begin
               pcWrite = 1'b0;
            end else if (eff_ret) begin
               if (!stack_empty) begin
                  pcInputSel = SEL_STACK;
                  pop_en     = 1'b1;
                  state_nxt  = ST_FLUSH;
               end else begin
                  pcWrite   = 1'b0;
                  state_nxt = ST_FAULT;
               end
            end else if (eff_jsb) begin
               if (!stack_full) begin
                  pcInputSel = SEL_JUMP;
                  push_en    = 1'b1;
                  state_nxt  = ST_FLUSH;
               end else begin
                  pcWrite   = 1'b0;
                  state_nxt = ST_FAULT;
               end
            end else if (eff_jmp) begin
               pcInputSel = SEL_JUMP;
               state_nxt  = ST_FLUSH;
            end else if (eff_br) begin
               pcAdderInputBSel = OPB_DISP;
               state_nxt        = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            flush = 1'b1;
            // A stall holds the squash so the wrong-path slot stays dead.
            if (stall) begin
               pcWrite = 1'b0;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_FAULT: begin
            pcWrite = 1'b0;
            flush   = 1'b1;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase

      if (rst) begin
         pcInputSel       = SEL_ADDER;
         pcAdderInputBSel = OPB_ONE;
         pcWrite          = 1'b1;
         flush            = 1'b0;
         push_en          = 1'b0;
         pop_en           = 1'b0;
      end
   end

   assign stackOutput = rst ? '0 : stack_top;
   assign stackEmpty  = rst ? 1'b1 : stack_empty;
   assign stackFull   = rst ? 1'b0 : stack_full;
   assign fault       = !rst && (state == ST_FAULT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pc_flow_controller.sv
// ---------------------------------------------------------------------------
// tb_pc_flow_controller : directed self-checking bench.            rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_flow_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, isJmp, isJsb, isRet, brTaken;
   logic [11:0] pushAdr;
   logic [1:0]  pcInputSel;
   logic        pcAdderInputBSel, pcWrite, flush;
   logic [11:0] stackOutput;
   logic        stackEmpty, stackFull, fault;

   int checks = 0;
   int errors = 0;

   pc_flow_controller #(
      .ADDR_WIDTH  (12),
      .STACK_DEPTH (8),
      .PTR_WIDTH   (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .isJmp            (isJmp),
      .isJsb            (isJsb),
      .isRet            (isRet),
      .brTaken          (brTaken),
      .pushAdr          (pushAdr),
      .pcInputSel       (pcInputSel),
      .pcAdderInputBSel (pcAdderInputBSel),
      .pcWrite          (pcWrite),
      .flush            (flush),
      .stackOutput      (stackOutput),
      .stackEmpty       (stackEmpty),
      .stackFull        (stackFull),
      .fault            (fault)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic j, input logic c, input logic r,
                        input logic b, input logic [11:0] a);
      stall = s; isJmp = j; isJsb = c; isRet = r; brTaken = b; pushAdr = a;
      #1;
   endtask

   task automatic check_seq(input string tag);
      check_value({tag, ".sel"},   32'(pcInputSel), 32'h0);
      check_value({tag, ".opb"},   32'(pcAdderInputBSel), 32'h1);
      check_value({tag, ".pcw"},   32'(pcWrite), 32'h1);
      check_value({tag, ".flush"}, 32'(flush), 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      stall = 0; isJmp = 0; isJsb = 0; isRet = 0; brTaken = 0; pushAdr = '0;

      // Reset defaults while rst is held
      cyc(); cyc();
      drive(1, 1, 1, 1, 1, 12'hfff);
      check_seq("rst");
      check_value("rst.fault", 32'(fault), 32'h0);
      check_value("rst.empty", 32'(stackEmpty), 32'h1);
      check_value("rst.full",  32'(stackFull), 32'h0);
      check_value("rst.top",   32'(stackOutput), 32'h0);
      drive(0, 0, 0, 0, 0, 12'h000);
      cyc(); rst = 1'b0;

      // Idle
      for (int i = 0; i < 3; i++) begin
         cyc(); drive(0, 0, 0, 0, 0, 12'h000);
         check_seq("idle");
         check_value("idle.empty", 32'(stackEmpty), 32'h1);
         check_value("idle.fault", 32'(fault), 32'h0);
      end

      // Two calls then two returns
      cyc(); drive(0, 0, 1, 0, 0, 12'h010);
      check_value("jsb1.sel", 32'(pcInputSel), 32'h2);
      check_value("jsb1.pcw", 32'(pcWrite), 32'h1);
      check_value("jsb1.flush", 32'(flush), 32'h0);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_value("jsb1f.flush", 32'(flush), 32'h1);
      check_value("jsb1f.sel", 32'(pcInputSel), 32'h0);
      check_value("jsb1f.top", 32'(stackOutput), 32'h010);
      check_value("jsb1f.empty", 32'(stackEmpty), 32'h0);
      cyc(); drive(0, 0, 1, 0, 0, 12'h020);
      check_value("jsb2.sel", 32'(pcInputSel), 32'h2);
      check_value("jsb2.flush", 32'(flush), 32'h0);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_value("jsb2f.flush", 32'(flush), 32'h1);
      check_value("jsb2f.top", 32'(stackOutput), 32'h020);
      cyc(); drive(0, 0, 0, 1, 0, 12'h000);
      check_value("ret1.sel", 32'(pcInputSel), 32'h1);
      check_value("ret1.top", 32'(stackOutput), 32'h020);
      check_value("ret1.pcw", 32'(pcWrite), 32'h1);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_value("ret1f.flush", 32'(flush), 32'h1);
      check_value("ret1f.top", 32'(stackOutput), 32'h010);
      cyc(); drive(0, 0, 0, 1, 0, 12'h000);
      check_value("ret2.sel", 32'(pcInputSel), 32'h1);
      check_value("ret2.top", 32'(stackOutput), 32'h010);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_value("ret2f.flush", 32'(flush), 32'h1);
      check_value("ret2f.empty", 32'(stackEmpty), 32'h1);
      check_value("ret2f.top", 32'(stackOutput), 32'h0);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_seq("post_ret");

      // Branch alone uses displacement operand
      cyc(); drive(0, 0, 0, 0, 1, 12'h000);
      check_value("br.sel", 32'(pcInputSel), 32'h0);
      check_value("br.opb", 32'(pcAdderInputBSel), 32'h0);
      check_value("br.pcw", 32'(pcWrite), 32'h1);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_value("brf.flush", 32'(flush), 32'h1);
      check_value("brf.opb", 32'(pcAdderInputBSel), 32'h1);

      // Stall in RUN holds PC with no flush
      cyc(); drive(1, 1, 0, 0, 0, 12'h000);
      check_value("stall.pcw", 32'(pcWrite), 32'h0);
      check_value("stall.sel", 32'(pcInputSel), 32'h0);
      check_value("stall.flush", 32'(flush), 32'h0);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_seq("after_stall");

      // Simultaneous ret/jmp/br with sp = 1: ret wins
      cyc(); drive(0, 0, 1, 0, 0, 12'h030);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      cyc(); drive(0, 1, 0, 1, 1, 12'h000);
      check_value("multi.sel", 32'(pcInputSel), 32'h1);
      check_value("multi.opb", 32'(pcAdderInputBSel), 32'h1);
      check_value("multi.top", 32'(stackOutput), 32'h030);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_value("multif.flush", 32'(flush), 32'h1);
      check_value("multif.empty", 32'(stackEmpty), 32'h1);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_seq("multi_post");

      // Fill the stack, ninth call overflows
      for (int i = 0; i < 8; i++) begin
         cyc(); drive(0, 0, 1, 0, 0, 12'(12'h100 + i));
         check_value("fill.sel", 32'(pcInputSel), 32'h2);
         check_value("fill.pcw", 32'(pcWrite), 32'h1);
         cyc(); drive(0, 0, 0, 0, 0, 12'h000);
         check_value("fill.flush", 32'(flush), 32'h1);
      end
      check_value("fill.full", 32'(stackFull), 32'h1);
      check_value("fill.top", 32'(stackOutput), 32'h107);
      cyc(); drive(0, 0, 1, 0, 0, 12'h1ff);
      check_value("ovf.pcw", 32'(pcWrite), 32'h0);
      check_value("ovf.flush", 32'(flush), 32'h0);
      for (int i = 0; i < 3; i++) begin
         cyc(); drive(0, 0, 0, (i == 1), (i == 2), 12'h000);
         check_value("ovf_fault.fault", 32'(fault), 32'h1);
         check_value("ovf_fault.pcw", 32'(pcWrite), 32'h0);
         check_value("ovf_fault.flush", 32'(flush), 32'h1);
         check_value("ovf_fault.top", 32'(stackOutput), 32'h107);
         check_value("ovf_fault.full", 32'(stackFull), 32'h1);
      end
      rst = 1'b1;
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      rst = 1'b0; #1;
      check_value("ovf_rst.empty", 32'(stackEmpty), 32'h1);
      check_value("ovf_rst.fault", 32'(fault), 32'h0);
      check_value("ovf_rst.top", 32'(stackOutput), 32'h0);
      check_seq("ovf_rst");

      // Underflow
      cyc(); drive(0, 0, 0, 1, 0, 12'h000);
      check_value("unf.pcw", 32'(pcWrite), 32'h0);
      check_value("unf.top", 32'(stackOutput), 32'h0);
      check_value("unf.sel", 32'(pcInputSel), 32'h0);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_value("unf_fault.fault", 32'(fault), 32'h1);
      check_value("unf_fault.pcw", 32'(pcWrite), 32'h0);
      rst = 1'b1;
      cyc(); rst = 1'b0; #1;
      check_value("unf_rst.fault", 32'(fault), 32'h0);

      // Jump, then stall during FLUSH; jsb in FLUSH ignored
      cyc(); drive(0, 1, 0, 0, 0, 12'h000);
      check_value("jmp.sel", 32'(pcInputSel), 32'h2);
      check_value("jmp.pcw", 32'(pcWrite), 32'h1);
      cyc(); drive(1, 0, 0, 0, 0, 12'h000);
      check_value("fstall1.flush", 32'(flush), 32'h1);
      check_value("fstall1.pcw", 32'(pcWrite), 32'h0);
      cyc(); drive(1, 0, 1, 0, 0, 12'h3ff);
      check_value("fstall2.flush", 32'(flush), 32'h1);
      check_value("fstall2.pcw", 32'(pcWrite), 32'h0);
      cyc(); drive(0, 0, 1, 0, 0, 12'h3ff);
      check_value("fstall3.flush", 32'(flush), 32'h1);
      check_value("fstall3.pcw", 32'(pcWrite), 32'h1);
      check_value("fstall3.sel", 32'(pcInputSel), 32'h0);
      cyc(); drive(0, 0, 0, 0, 0, 12'h000);
      check_seq("fstall_done");
      check_value("fstall_done.empty", 32'(stackEmpty), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_flow_controller.md
Name: pc_flow_controller

Overview:
- Sequences the fetch stage: drives the PC-input mux select, the PC-adder operand select and the PC write enable.
- Owns the return-address stack whose top entry feeds the fetch stage's stack input.
- Resolves jump (jmp), call (jsb), return (ret), taken branch and stall requests from decode into one redirect per cycle.
- Issues a one-cycle flush of the wrong-path instruction after each redirect, and freezes fetch on any stack fault.

Parameters:
- ADDR_WIDTH, 12, PC / return-address width.
- STACK_DEPTH, 8, number of return-stack entries.
- PTR_WIDTH, 4, stack-pointer width; must hold 0..STACK_DEPTH inclusive.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; pipeline hazard from downstream.
- isJmp  in  1  decode holds an unconditional jump.
- isJsb  in  1  decode holds a call.
- isRet  in  1  decode holds a return.
- brTaken  in  1  decode holds a taken branch; the PC-relative displacement is supplied to fetch directly.
- pushAdr  in  ADDR_WIDTH  return address to push on isJsb (call PC + 1).
- pcInputSel  out  2  00 = adder result, 01 = stack top, 10 = jump address; 11 is never driven.
- pcAdderInputBSel  out  1  0 = displacement, 1 = constant 1.
- pcWrite  out  1  PC load enable.
- flush  out  1  squash the instruction currently in decode.
- stackOutput  out  ADDR_WIDTH  top-of-stack entry, combinational; 0 when the stack is empty.
- stackEmpty  out  1  sp == 0.
- stackFull  out  1  sp == STACK_DEPTH.
- fault  out  1  sticky overflow/underflow indication.

Behaviour:
- FSM states: RUN, FLUSH, FAULT. Reset enters RUN with sp = 0 and all entries cleared.
- While rst is high, outputs are forced to defaults: pcInputSel = 00, pcAdderInputBSel = 1, pcWrite = 1, flush = 0, fault = 0, stackEmpty = 1, stackFull = 0, stackOutput = 0.
- Effective controls are the inputs gated with (state == RUN). In FLUSH and FAULT all control inputs are ignored.
- Priority in RUN, highest first: stall > isRet > isJsb > isJmp > brTaken > sequential.
- stall: pcWrite = 0, selects at default, no stack change, state unchanged.
- isRet with sp > 0:
  - pcInputSel = 01; stackOutput = entry[sp-1] during that cycle.
  - sp decrements at the clock edge.
  - Next state FLUSH.
- isRet with sp == 0 (underflow): pcWrite = 0, next state FAULT.
- isJsb with sp < STACK_DEPTH:
  - pcInputSel = 10; entry[sp] <= pushAdr; sp increments.
  - Next state FLUSH.
- isJsb with sp == STACK_DEPTH (overflow): no write, pcWrite = 0, next state FAULT.
- isJmp: pcInputSel = 10, next state FLUSH.
- brTaken: pcInputSel = 00, pcAdderInputBSel = 0, next state FLUSH.
- Sequential (no control asserted): pcInputSel = 00, pcAdderInputBSel = 1, pcWrite = 1, state stays RUN.
- FLUSH:
  - flush = 1; PC advances sequentially (pcWrite = 1, pcInputSel = 00, pcAdderInputBSel = 1).
  - Returns to RUN next cycle.
  - If stall is high: pcWrite = 0, flush stays 1, state remains FLUSH.
- FAULT:
  - pcWrite = 0, flush = 1, fault = 1; stack frozen.
  - Exit only via rst.
- Redirect latency: a redirect selected in cycle N loads the PC at the end of cycle N. flush is high in cycle N+1 only, absent stall.
- Simultaneous control inputs are legal; only the highest-priority one acts, and the others are dropped with no side effect.
- Reset mid-FLUSH or mid-FAULT returns to RUN and empties the stack on the same edge.
- Stack contents are not cleared on pop; only sp moves.

Decomposition:
- Shared package holds:
  - PC-select constants: SEL_ADDER = 2'b00, SEL_STACK = 2'b01, SEL_JUMP = 2'b10.
  - Adder-operand constants: OPB_DISP = 0, OPB_ONE = 1.
  - The FSM state encoding.
- One sub-module: return_stack (parameterised LIFO with push, pop, top, empty, full; synchronous reset).
- The controller instantiates return_stack and contains the priority decode and the FSM.

Test Plan:
- Reset, then idle 3 cycles -> pcInputSel = 00, pcAdderInputBSel = 1, pcWrite = 1, flush = 0, stackEmpty = 1, fault = 0 every cycle.
- isJsb with pushAdr = 12'h010, then isJsb with 12'h020, then isRet twice (with a FLUSH cycle between each) -> pcInputSel = 10, 10, 01, 01. stackOutput reads 12'h020 at the first return and 12'h010 at the second. Ends with stackEmpty = 1; flush pulses once after each redirect.
- brTaken and isJmp and isRet asserted together with sp = 1 -> the ret wins: pcInputSel = 01, sp becomes 0. Branch and jump are dropped. Next cycle flush = 1.
- Nine consecutive isJsb (each followed by its FLUSH cycle) -> the first eight push and stackFull = 1. The ninth gives pcWrite = 0 and FAULT. fault stays 1 and pcWrite stays 0 until rst; after rst, stackEmpty = 1.
- isRet on an empty stack -> FAULT immediately, pcWrite = 0, stackOutput = 0.
- isJmp, then stall held 2 cycles during FLUSH -> flush stays 1 and pcWrite = 0 for both stall cycles. isJsb asserted during FLUSH is ignored (sp unchanged). Returns to RUN after stall drops.
